// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared constants for the bit-serial add/subtract unit
package serial_alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder used as the serial bit-slice
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub8.sv
// serial_addsub8: bit-serial a+b / a-b with carry and signed-overflow flags
module serial_addsub8
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic             c_msb_in;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last;

    assign last = cnt == CW'(WIDTH - 1);

    full_adder u_fa (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .cin(carry),
        .s  (fa_s),
        .c  (fa_c)
    );

    // Control: IDLE -> RUN for WIDTH bit cycles -> one-cycle DONE -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: subtraction is a + ~b + 1, so B is inverted and carry seeded with op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a     <= '0;
            sh_b     <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            sh_a     <= a;
            sh_b     <= b ^ {WIDTH{op == OP_SUB}};
            carry    <= op;
            c_msb_in <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (state == ST_RUN) begin
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            result <= {fa_s, result[WIDTH-1:1]};
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
            if (last) begin
                c_msb_in <= carry;
                cout     <= fa_c;
                ovf      <= carry ^ fa_c;
            end
        end
    end

endmodule
